alu_issue_ctrl: RTL and testbench

//  Initiator side of the ALU interface: accepts one instruction per valid/ready transfer and decodes its opcode into alu_operation/alu_ALUOp.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_decode.sv | 45 ++++
 rtl/alu_issue_ctrl.sv | 163 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, ALU function codes, ALU mode encodings and FSM states for the ALU issue controller.
package alu_pkg;

  localparam logic [5:0] OpLd  = 6'h00;
  localparam logic [5:0] OpAdd = 6'h01;
  localparam logic [5:0] OpMul = 6'h09;
  localparam logic [5:0] OpDiv = 6'h0A;
  localparam logic [5:0] OpMod = 6'h0B;
  localparam logic [5:0] OpLdi = 6'h10;
  localparam logic [5:0] OpSt  = 6'h11;
  localparam logic [5:0] OpBeq = 6'h12;
  localparam logic [5:0] OpBne = 6'h13;

  localparam logic [5:0] FnPass = 6'h00;
  localparam logic [5:0] FnAdd  = 6'h01;
  localparam logic [5:0] FnSub  = 6'h02;
  localparam logic [5:0] FnAnd  = 6'h03;
  localparam logic [5:0] FnOr   = 6'h04;
  localparam logic [5:0] FnXor  = 6'h05;
  localparam logic [5:0] FnNot  = 6'h06;
  localparam logic [5:0] FnShl  = 6'h07;
  localparam logic [5:0] FnShr  = 6'h08;
  localparam logic [5:0] FnMul  = 6'h09;
  localparam logic [5:0] FnDiv  = 6'h0A;
  localparam logic [5:0] FnMod  = 6'h0B;

  typedef enum logic [1:0] {
    AluOpPass   = 2'b00,
    AluOpBeqImm = 2'b01,
    AluOpBne    = 2'b10,
    AluOpAddr   = 2'b11
  } aluop_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StResp = 2'b10
  } state_e;

endpackage

// File: rtl/alu_decode.sv
// Combinational opcode decoder: function code, ALU mode and operand/category flags.
module alu_decode
  import alu_pkg::*;
(
  input  logic [5:0] opcode_i,
  output logic [5:0] operation_o,
  output aluop_e     aluop_o,
  output logic       src2_is_imm_o,
  output logic       is_branch_o,
  output logic       is_muldiv_o,
  output logic       illegal_o
);

  always_comb begin
    operation_o   = FnPass;
    aluop_o       = AluOpPass;
    src2_is_imm_o = 1'b0;
    is_branch_o   = 1'b0;
    is_muldiv_o   = 1'b0;
    illegal_o     = 1'b0;
    if (opcode_i >= OpAdd && opcode_i <= OpMod) begin
      // Register-register ops use the opcode directly as the ALU function code.
      operation_o = opcode_i;
      is_muldiv_o = (opcode_i >= OpMul);
    end else begin
      unique case (opcode_i)
        OpLd, OpSt: begin
          aluop_o       = AluOpAddr;
          src2_is_imm_o = 1'b1;
        end
        OpLdi: begin
          aluop_o       = AluOpBeqImm;
          src2_is_imm_o = 1'b1;
        end
        OpBeq:   is_branch_o = 1'b1;
        OpBne: begin
          aluop_o     = AluOpBne;
          is_branch_o = 1'b1;
        end
        default: illegal_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue-side ALU controller: IDLE -> EXEC -> RESP handshake around a combinational ALU.
// ALU_MULDIV_WAIT_EN: hold EXEC for MULDIV_CYCLES cycles on MUL/DIV/MOD.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_opcode,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] in_imm,
  output logic [DATA_W-1:0] alu_data1,
  output logic [DATA_W-1:0] alu_data2,
  output logic [5:0]        alu_operation,
  output logic [1:0]        alu_ALUOp,
  input  logic              alu_zero,
  input  logic [DATA_W-1:0] alu_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_taken,
  output logic              out_error
);

  logic [5:0] dec_operation;
  aluop_e     dec_aluop;
  logic       dec_src2_is_imm, dec_is_branch, dec_is_muldiv, dec_illegal;

  alu_decode u_decode (
    .opcode_i      (in_opcode),
    .operation_o   (dec_operation),
    .aluop_o       (dec_aluop),
    .src2_is_imm_o (dec_src2_is_imm),
    .is_branch_o   (dec_is_branch),
    .is_muldiv_o   (dec_is_muldiv),
    .illegal_o     (dec_illegal)
  );

  state_e            state_d, state_q;
  logic [DATA_W-1:0] data1_d, data1_q, data2_d, data2_q, result_d, result_q;
  logic [5:0]        operation_d, operation_q;
  logic [1:0]        aluop_d, aluop_q;
  logic              taken_d, taken_q, error_d, error_q, branch_d, branch_q;
  logic              capture, div_by_zero;

  // Caught at accept so the ALU's undefined divide result is never sampled.
  assign div_by_zero = ((in_opcode == OpDiv) || (in_opcode == OpMod)) && (in_b == '0);

`ifdef ALU_MULDIV_WAIT_EN
  localparam logic [3:0] MulDivLoad = 4'(MULDIV_CYCLES - 1);
  logic [3:0] cnt_d, cnt_q;
  logic       muldiv_d, muldiv_q;
`else
  logic unused_muldiv;
  assign unused_muldiv = dec_is_muldiv ^ (^4'(MULDIV_CYCLES));
`endif

  always_comb begin
    state_d     = state_q;
    data1_d     = data1_q;
    data2_d     = data2_q;
    operation_d = operation_q;
    aluop_d     = aluop_q;
    result_d    = result_q;
    taken_d     = taken_q;
    error_d     = error_q;
    branch_d    = branch_q;
    capture     = 1'b0;
`ifdef ALU_MULDIV_WAIT_EN
    cnt_d       = cnt_q;
    muldiv_d    = muldiv_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (dec_illegal || div_by_zero) begin
            result_d = '0;
            taken_d  = 1'b0;
            error_d  = 1'b1;
            state_d  = StResp;
          end else begin
            data1_d     = in_a;
            data2_d     = dec_src2_is_imm ? in_imm : in_b;
            operation_d = dec_operation;
            aluop_d     = dec_aluop;
            branch_d    = dec_is_branch;
`ifdef ALU_MULDIV_WAIT_EN
            muldiv_d    = dec_is_muldiv;
            cnt_d       = MulDivLoad;
`endif
            state_d     = StExec;
          end
        end
      end
      StExec: begin
`ifdef ALU_MULDIV_WAIT_EN
        capture = !muldiv_q || (cnt_q == 4'd0);
        if (!capture) cnt_d = cnt_q - 4'd1;
`else
        capture = 1'b1;
`endif
        if (capture) begin
          result_d = alu_result;
          taken_d  = branch_q & alu_zero;
          error_d  = 1'b0;
          state_d  = StResp;
        end
      end
      StResp: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      data1_q     <= '0;
      data2_q     <= '0;
      operation_q <= '0;
      aluop_q     <= '0;
      result_q    <= '0;
      taken_q     <= 1'b0;
      error_q     <= 1'b0;
      branch_q    <= 1'b0;
`ifdef ALU_MULDIV_WAIT_EN
      cnt_q       <= '0;
      muldiv_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      data1_q     <= data1_d;
      data2_q     <= data2_d;
      operation_q <= operation_d;
      aluop_q     <= aluop_d;
      result_q    <= result_d;
      taken_q     <= taken_d;
      error_q     <= error_d;
      branch_q    <= branch_d;
`ifdef ALU_MULDIV_WAIT_EN
      cnt_q       <= cnt_d;
      muldiv_q    <= muldiv_d;
`endif
    end
  end

  assign in_ready      = (state_q == StIdle);
  assign out_valid     = (state_q == StResp);
  assign alu_data1     = data1_q;
  assign alu_data2     = data2_q;
  assign alu_operation = operation_q;
  assign alu_ALUOp     = aluop_q;
  assign out_result    = result_q;
  assign out_taken     = taken_q;
  assign out_error     = error_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU and an instruction-level reference model.
module tb_alu_issue_ctrl;

  localparam int unsigned W = 32;
  localparam int unsigned C = 4;

  logic         clock, reset, in_valid, in_ready, alu_zero, out_valid, out_ready;
  logic         out_taken, out_error;
  logic [5:0]   in_opcode, alu_operation;
  logic [1:0]   alu_ALUOp;
  logic [W-1:0] in_a, in_b, in_imm, alu_data1, alu_data2, alu_result, out_result;

  int n_cmp = 0;
  int n_bad = 0;

  alu_issue_ctrl #(.DATA_W(W), .MULDIV_CYCLES(C)) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_opcode     (in_opcode),
    .in_a          (in_a),
    .in_b          (in_b),
    .in_imm        (in_imm),
    .alu_data1     (alu_data1),
    .alu_data2     (alu_data2),
    .alu_operation (alu_operation),
    .alu_ALUOp     (alu_ALUOp),
    .alu_zero      (alu_zero),
    .alu_result    (alu_result),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_taken     (out_taken),
    .out_error     (out_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural combinational ALU; divide by zero yields a poison value.
  always_comb begin
    alu_result = '0;
    alu_zero   = (alu_ALUOp == 2'b10) ? (alu_data1 != alu_data2) : (alu_data1 == alu_data2);
    case (alu_ALUOp)
      2'b00: case (alu_operation)
        6'h01: alu_result = alu_data1 + alu_data2;
        6'h02: alu_result = alu_data1 - alu_data2;
        6'h03: alu_result = alu_data1 & alu_data2;
        6'h04: alu_result = alu_data1 | alu_data2;
        6'h05: alu_result = alu_data1 ^ alu_data2;
        6'h06: alu_result = ~alu_data1;
        6'h07: alu_result = alu_data1 << alu_data2[4:0];
        6'h08: alu_result = alu_data1 >> alu_data2[4:0];
        6'h09: alu_result = alu_data1 * alu_data2;
        6'h0A: alu_result = (alu_data2 != 0) ? alu_data1 / alu_data2 : 32'hDEAD_BEEF;
        6'h0B: alu_result = (alu_data2 != 0) ? alu_data1 % alu_data2 : 32'hDEAD_BEEF;
        default: alu_result = '0;
      endcase
      2'b10:   alu_result = alu_data1 - alu_data2;
      default: alu_result = alu_data2;
    endcase
  end

  // ---------------- reference model (instruction level) ----------------
  function automatic bit ref_legal(input logic [5:0] op);
    return (op <= 6'h0B) || (op >= 6'h10 && op <= 6'h13);
  endfunction

  function automatic bit ref_error(input logic [5:0] op, input logic [W-1:0] b);
    return !ref_legal(op) || ((op == 6'h0A || op == 6'h0B) && b == 0);
  endfunction

  function automatic logic [W-1:0] ref_result(input logic [5:0] op,
                                              input logic [W-1:0] a, b, imm);
    if (ref_error(op, b)) return '0;
    case (op)
      6'h01: return a + b;
      6'h02: return a - b;
      6'h03: return a & b;
      6'h04: return a | b;
      6'h05: return a ^ b;
      6'h06: return ~a;
      6'h07: return a << b[4:0];
      6'h08: return a >> b[4:0];
      6'h09: return a * b;
      6'h0A: return a / b;
      6'h0B: return a % b;
      default: return imm;
    endcase
  endfunction

  function automatic bit ref_taken(input logic [5:0] op, input logic [W-1:0] a, b);
    if (op == 6'h12) return a == b;
    if (op == 6'h13) return a != b;
    return 1'b0;
  endfunction

  function automatic logic [1:0] ref_aluop(input logic [5:0] op);
    case (op)
      6'h00, 6'h11: return 2'b11;
      6'h10:        return 2'b01;
      6'h13:        return 2'b10;
      default:      return 2'b00;
    endcase
  endfunction

  // Negedges after the accept edge until out_valid is seen.
  function automatic int ref_lat(input logic [5:0] op, input logic [W-1:0] b);
    if (ref_error(op, b)) return 0;
`ifdef ALU_MULDIV_WAIT_EN
    if (op >= 6'h09 && op <= 6'h0B) return C;
`endif
    return 1;
  endfunction

  // Issue one instruction, check EXEC drives, latency, response and backpressure.
  task automatic run_op(input string tag, input logic [5:0] op,
                        input logic [W-1:0] a, b, imm, input int hold);
    int k;
    logic [W-1:0] r_hold;
    logic t_hold, e_hold;
    bit is_br;
    is_br = (op == 6'h12) || (op == 6'h13);
    k = 0;
    while (!in_ready && k < 50) begin @(negedge clock); k++; end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL %s in_ready_wait: got %b want 1", tag, in_ready);
    end
    in_valid = 1'b1; in_opcode = op; in_a = a; in_b = b; in_imm = imm;
    out_ready = (hold == 0);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_imm = $urandom;
    if (!ref_error(op, b)) begin
      n_cmp++;
      if (alu_ALUOp !== ref_aluop(op)) begin
        n_bad++; $display("FAIL %s aluop: got %b want %b", tag, alu_ALUOp, ref_aluop(op));
      end
      if (!is_br) begin
        n_cmp++;
        if (alu_operation !== ((op <= 6'h0B) ? op : 6'h00)) begin
          n_bad++; $display("FAIL %s operation: got %h op %h", tag, alu_operation, op);
        end
      end
      n_cmp++;
      if (alu_data2 !== ((op == 6'h00 || op == 6'h10 || op == 6'h11) ? imm : b)) begin
        n_bad++; $display("FAIL %s data2: got %h", tag, alu_data2);
      end
      if (op != 6'h10) begin
        n_cmp++;
        if (alu_data1 !== a) begin
          n_bad++; $display("FAIL %s data1: got %h want %h", tag, alu_data1, a);
        end
      end
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_bad++; $display("FAIL %s in_ready_exec: got %b want 0", tag, in_ready);
      end
    end
    k = 0;
    while (!out_valid && k < 40) begin @(negedge clock); k++; end
    n_cmp++;
    if (k != ref_lat(op, b)) begin
      n_bad++; $display("FAIL %s latency: got %0d want %0d", tag, k, ref_lat(op, b));
    end
    if (!is_br) begin
      n_cmp++;
      if (out_result !== ref_result(op, a, b, imm)) begin
        n_bad++;
        $display("FAIL %s result: got %h want %h", tag, out_result, ref_result(op, a, b, imm));
      end
    end
    n_cmp++;
    if (out_taken !== ref_taken(op, a, b) || out_error !== ref_error(op, b)) begin
      n_bad++; $display("FAIL %s taken/error: got %b/%b want %b/%b", tag, out_taken, out_error,
                        ref_taken(op, a, b), ref_error(op, b));
    end
    r_hold = out_result; t_hold = out_taken; e_hold = out_error;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== r_hold ||
          out_taken !== t_hold || out_error !== e_hold) begin
        n_bad++; $display("FAIL %s backpressure: valid %b ready %b result %h want 1 0 %h",
                          tag, out_valid, in_ready, out_result, r_hold);
      end
    end
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL %s release: valid %b ready %b want 0 1", tag, out_valid, in_ready);
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_cmp++;
    if (out_valid !== 1'b0 || out_result !== '0 || out_taken !== 1'b0 || out_error !== 1'b0 ||
        alu_data1 !== '0 || alu_data2 !== '0 || alu_operation !== '0 || alu_ALUOp !== '0 ||
        in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s zero: v%b r%h t%b e%b d1%h d2%h op%h m%b rdy%b want all 0, rdy 1", tag,
               out_valid, out_result, out_taken, out_error, alu_data1, alu_data2,
               alu_operation, alu_ALUOp, in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_opcode = '0; in_a = '0; in_b = '0; in_imm = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_all_zero("reset");
  endtask

  task automatic test_directed();
    run_op("add", 6'h01, 5, 7, 0, 0);
    run_op("bne", 6'h13, 3, 3, 0, 0);
    run_op("beq", 6'h12, 3, 3, 0, 0);
    run_op("beq_ne", 6'h12, 3, 4, 0, 0);
    run_op("ldi", 6'h10, 0, 0, 32'h1234, 0);
    run_op("ld", 6'h00, 9, 0, 32'h40, 0);
    run_op("st", 6'h11, 2, 8, 32'h80, 0);
    run_op("div0", 6'h0A, 10, 0, 0, 0);
    run_op("mod0", 6'h0B, 10, 0, 0, 0);
    run_op("ill3f", 6'h3F, 1, 2, 3, 0);
    run_op("mul", 6'h09, 6, 7, 0, 0);
    run_op("div", 6'h0A, 100, 7, 0, 0);
  endtask

  task automatic test_backpressure();
    run_op("bp_sub", 6'h02, 50, 8, 0, 5);
    run_op("bp_ill", 6'h0C, 0, 0, 0, 3);
  endtask

  task automatic test_reset_midflight();
    // Reset while in EXEC.
    in_valid = 1'b1; in_opcode = 6'h01; in_a = 32'h11; in_b = 32'h22; in_imm = 0;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_all_zero("rst_exec");
    @(negedge clock);
    check_all_zero("rst_exec_after");
    // Reset while holding a response.
    in_valid = 1'b1; in_opcode = 6'h05; in_a = 32'hF0; in_b = 32'h0F; out_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; out_ready = 1'b1;
    check_all_zero("rst_resp");
  endtask

  task automatic test_random();
    logic [5:0] op;
    logic [W-1:0] a, b;
    int sel;
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 19);
      if (sel < 12)      op = 6'(sel);
      else if (sel < 16) op = 6'(6'h10 + (sel - 12));
      else               op = 6'($urandom_range(6'h14, 6'h3F));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : a) : $urandom;
      run_op("rand", op, a, b, $urandom, $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
